axi_sram_responder: RTL and testbench
=====================================

// Module: axi_sram_responder
//
// PURPOSE
// - AXI4 responder (subordinate) that terminates the CPU subsystem's bus port on on-chip SRAM.
// - Converts AXI bursts into single-port SRAM accesses: req/we/be/addr/wdata, with rdata one cycle after req.
// - Instantiated inside memory_subsystem, in front of the SRAM macro.
// - Serves one transaction at a time. Write and read bursts are never overlapped.
//
// PARAMETERS
// - DataWidth     64  AXI and SRAM data width in bits; power of two, at least 32.
// - MemAddrWidth  16  SRAM word-address width. Memory holds 2**MemAddrWidth words.
//
// PORTS
// - clk_i        in   1             Clock. Single clock domain.
// - rst_ni       in   1             Asynchronous reset, active low.
// - axi_req_i    in   axi_req_t     AXI4 request: aw/w/ar channels, b_ready, r_ready.
// - axi_resp_o   out  axi_resp_t    AXI4 response: aw/w/ar ready, b and r channels.
// - mem_req_o    out  1             SRAM access strobe. One access per asserted cycle.
// - mem_we_o     out  1             1 = write, 0 = read. Qualified by mem_req_o.
// - mem_addr_o   out  MemAddrWidth  SRAM word address.
// - mem_be_o     out  DataWidth/8   Byte enables; the W strobe on writes, all ones on reads.
// - mem_wdata_o  out  DataWidth     Write data, taken from w.data.
// - mem_rdata_i  in   DataWidth     Read data. Valid exactly 1 cycle after a read mem_req_o.
//
// BEHAVIOUR
// - Reset (async, rst_ni=0): FSM to IDLE and FIFO emptied.
//   - Every ready, valid and mem_* output is 0.
//   - The read-arbiter priority flag is set so that the first tie goes to the write.
//   - Reset mid-burst abandons the transaction. No B or R beat is produced for it.
// - FSM states: IDLE, WRITE, WRITE_RESP, READ.
// - IDLE:
//   - aw_ready = aw_valid && grant_w.
//   - ar_ready = ar_valid && !grant_w.
//   - If only one channel is valid, it is granted.
//   - If both are valid, round-robin: grant the channel not served last.
//   - On handshake, latch id, addr, len, size and burst, then move to WRITE or READ.
// - Address rules:
//   - Word address = (byte_addr >> log2(DataWidth/8)) mod 2**MemAddrWidth. Out-of-range addresses wrap; no DECERR.
//   - INCR: byte_addr += 2**size after each beat.
//   - FIXED: byte_addr is held.
//   - WRAP: handled as INCR.
//   - Unaligned start address is aligned down for the word address. Byte lanes come from w.strb only.
// - WRITE:
//   - w_ready = 1.
//   - Each W handshake drives mem_req=1, we=1, be=w.strb and wdata=w.data in the same cycle (combinational from w_valid).
//   - Beat counter runs 0..len. After beat len, go to WRITE_RESP.
//   - w.last is ignored. The counter alone ends the burst.
// - WRITE_RESP:
//   - b_valid = 1, b.id = latched id, b.resp = OKAY.
//   - On b_ready, go to IDLE.
// - READ:
//   - Issue mem_req=1, we=0 while issued <= len and (fifo_count + inflight) < 2.
//   - At most one read is in flight.
//   - One cycle after a read is issued, push {mem_rdata_i, id, last = (beat == len)} into the 2-entry FIFO.
//   - r_valid = FIFO not empty. r.resp = OKAY. Pop on r_valid && r_ready.
//   - With r_ready held high, throughput is 1 beat/cycle; first R beat is 2 cycles after the AR handshake.
//   - Exit to IDLE once all len+1 beats are issued, nothing is in flight, and the FIFO is empty (the last beat has popped).
//   - r_ready low never drops or duplicates data. Issue stalls when the FIFO is full.
// - Simultaneous events:
//   - A push and a pop in the same cycle leave the FIFO count unchanged.
//   - AW/AR arriving outside IDLE are held off (ready = 0).
// - Width rules:
//   - Beat counter is 8 bits and covers len up to 255.
//   - Byte address is 64 bits, AXI addr width. The increment wraps modulo 2**64.
//
// STRUCTURE
// - Shared package core_v_mcu_pkg: responder_state_e enum, and the OKAY constant for axi resp.
// - axi_req_t / axi_resp_t come from core_v_mcu_axi_pkg.
// - Sub-module axi_sram_rd_fifo: 2-entry FIFO of {data, id, last}, with push/pop/full/empty and count.
//
// TESTING
// - Single write then read:
//   - Stimulus: AW addr=0x40, len=0, strb=0xFF, data=0xDEAD_BEEF_0123_4567; then AR addr=0x40, len=0.
//   - Required: mem_addr=8; B OKAY with matching id; R returns the same data with last=1.
// - INCR burst of 4 with r_ready stuck low for 5 cycles:
//   - Required: 2 reads issued, then stall.
//   - Required: data in order at word addresses 8..11, last on beat 3 only, no beat lost.
// - FIXED burst of 3 writes to 0x100:
//   - Required: three mem writes, all at word address 0x20; final memory word = third beat.
// - AW and AR valid in the same cycle, repeated twice:
//   - Required: first grant write, second grant read (round-robin); no overlap of mem accesses.
// - Address 0x8_0000 with MemAddrWidth=16:
//   - Required: mem_addr wraps to 0x0000; response OKAY.
// - rst_ni pulsed low mid read burst (beat 2 of 8):
//   - Required: all outputs 0 immediately; FIFO empty; the next AR is served from IDLE correctly.

Source files
------------

// File: rtl/axi_sram_responder_pkg.sv
// Shared types for the AXI4-to-SRAM responder: channel structs, FSM states,
// read-FIFO entry and the burst address step.
package axi_sram_responder_pkg;

  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRITE_RESP,
    ST_READ
  } responder_state_e;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_ax_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiIdWidth-1:0]   id;
    logic                    last;
  } rd_entry_t;

  // WRAP bursts deliberately take the INCR path.
  function automatic logic [AxiAddrWidth-1:0] axi_next_addr(
    input logic [AxiAddrWidth-1:0] addr,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    if (burst == AXI_BURST_FIXED) return addr;
    return addr + (AxiAddrWidth'(1) << size);
  endfunction

endpackage

// File: rtl/axi_sram_responder_rd_fifo.sv
// Two-entry FIFO holding SRAM read beats {data, id, last} until the R
// channel accepts them.
module axi_sram_responder_rd_fifo
  import axi_sram_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i_push,
  input  logic       i_pop,
  input  rd_entry_t  i_data,
  output rd_entry_t  o_head,
  output logic       o_full,
  output logic       o_empty,
  output logic [1:0] o_count
);

  rd_entry_t  r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A push into a full FIFO is only accepted when a pop frees a slot.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate terminating on a single-port SRAM with one-cycle read
// latency; serves one burst at a time. DataWidth must match AxiDataWidth.
module axi_sram_responder
  import axi_sram_responder_pkg::*;
#(
  parameter int unsigned DataWidth    = AxiDataWidth,
  parameter int unsigned MemAddrWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_req_t                axi_req_i,
  output axi_resp_t               axi_resp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [DataWidth/8-1:0]  mem_be_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i
);

  localparam int unsigned AddrLsb = $clog2(DataWidth / 8);

  responder_state_e        r_state;
  logic [AxiIdWidth-1:0]   r_id;
  logic [AxiAddrWidth-1:0] r_addr;
  logic [7:0]              r_len;
  logic [7:0]              r_beat;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic                    r_prio_w;
  logic                    r_rd_done;
  logic                    r_inflight;
  logic                    r_inflight_last;
  logic                    r_en;

  logic                    w_grant_w;
  logic                    w_idle;
  logic                    w_aw_hs;
  logic                    w_ar_hs;
  logic                    w_w_hs;
  logic                    w_b_hs;
  logic                    w_pop;
  logic                    w_last_pop;
  logic                    w_rd_issue;
  logic [2:0]              w_occupancy;
  logic [MemAddrWidth-1:0] w_word_addr;
  rd_entry_t               w_push_data;
  rd_entry_t               w_fifo_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [1:0]              w_fifo_count;
  logic                    w_unused;

  assign w_unused = axi_req_i.w.last ^ w_fifo_full;

  // r_en keeps every ready low while reset is asserted, even with valids high.
  assign w_idle    = r_en && (r_state == ST_IDLE);
  assign w_grant_w = axi_req_i.aw_valid && (!axi_req_i.ar_valid || r_prio_w);
  assign w_aw_hs   = w_idle && w_grant_w;
  assign w_ar_hs   = w_idle && axi_req_i.ar_valid && !w_grant_w;
  assign w_w_hs    = (r_state == ST_WRITE) && axi_req_i.w_valid;
  assign w_b_hs    = (r_state == ST_WRITE_RESP) && axi_req_i.b_ready;

  assign w_pop      = !w_fifo_empty && axi_req_i.r_ready;
  assign w_last_pop = w_pop && w_fifo_head.last;

  // Counting a same-cycle pop as free space sustains one R beat per cycle.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_issue  = (r_state == ST_READ) && !r_rd_done && (w_occupancy < 3'd2);

  assign w_word_addr = r_addr[AddrLsb +: MemAddrWidth];

  always_comb begin
    mem_req_o   = w_w_hs || w_rd_issue;
    mem_we_o    = w_w_hs;
    mem_addr_o  = (w_w_hs || w_rd_issue) ? w_word_addr : '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_w_hs) begin
      mem_be_o    = axi_req_i.w.strb;
      mem_wdata_o = axi_req_i.w.data;
    end else if (w_rd_issue) begin
      mem_be_o = '1;
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = w_aw_hs;
    axi_resp_o.ar_ready = w_ar_hs;
    axi_resp_o.w_ready  = (r_state == ST_WRITE);
    axi_resp_o.b_valid  = (r_state == ST_WRITE_RESP);
    axi_resp_o.b.id     = r_id;
    axi_resp_o.b.resp   = AXI_RESP_OKAY;
    axi_resp_o.r_valid  = !w_fifo_empty;
    axi_resp_o.r.id     = w_fifo_head.id;
    axi_resp_o.r.data   = w_fifo_head.data;
    axi_resp_o.r.last   = w_fifo_head.last;
    axi_resp_o.r.resp   = AXI_RESP_OKAY;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state         <= ST_IDLE;
      r_beat          <= 8'd0;
      r_prio_w        <= 1'b1;
      r_rd_done       <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_en            <= 1'b0;
    end else begin
      r_en            <= 1'b1;
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue && (r_beat == r_len);
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_state  <= ST_WRITE;
            r_beat   <= 8'd0;
            r_prio_w <= 1'b0;
          end else if (w_ar_hs) begin
            r_state   <= ST_READ;
            r_beat    <= 8'd0;
            r_rd_done <= 1'b0;
            r_prio_w  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (w_w_hs) begin
            if (r_beat == r_len) r_state <= ST_WRITE_RESP;
            else                 r_beat  <= r_beat + 8'd1;
          end
        end
        ST_WRITE_RESP: begin
          if (w_b_hs) r_state <= ST_IDLE;
        end
        ST_READ: begin
          if (w_rd_issue) begin
            if (r_beat == r_len) r_rd_done <= 1'b1;
            else                 r_beat    <= r_beat + 8'd1;
          end
          if (w_last_pop) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_aw_hs) begin
      r_id    <= axi_req_i.aw.id;
      r_addr  <= axi_req_i.aw.addr;
      r_len   <= axi_req_i.aw.len;
      r_size  <= axi_req_i.aw.size;
      r_burst <= axi_req_i.aw.burst;
    end else if (w_ar_hs) begin
      r_id    <= axi_req_i.ar.id;
      r_addr  <= axi_req_i.ar.addr;
      r_len   <= axi_req_i.ar.len;
      r_size  <= axi_req_i.ar.size;
      r_burst <= axi_req_i.ar.burst;
    end else if (w_w_hs || w_rd_issue) begin
      r_addr <= axi_next_addr(r_addr, r_size, r_burst);
    end
  end

  assign w_push_data = '{data: mem_rdata_i, id: r_id, last: r_inflight_last};

  axi_sram_responder_rd_fifo u_rd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a behavioural SRAM behind it.
module tb_axi_sram_responder;
  import axi_sram_responder_pkg::*;

  logic        clk;
  logic        rst_n;
  axi_req_t    req;
  axi_resp_t   rsp;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        sram_init;
  logic [63:0] sram [65536];
  logic [63:0] exp_data [16];
  int          checks;
  int          errors;

  axi_sram_responder #(.DataWidth(64), .MemAddrWidth(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (rsp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pattern(input logic [15:0] w);
    return {16'hC0DE, w, 16'h5A5A, ~w};
  endfunction

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 65536; i++) sram[i] <= pattern(16'(i));
    end else if (mem_req && mem_we) begin
      for (int b = 0; b < 8; b++)
        if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [15:0] word0, input int step,
                          input logic [7:0] strb);
    int n;
    @(negedge clk);
    req.aw = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
    req.aw_valid = 1'b1;
    #1;
    n = 0;
    while (!rsp.aw_ready && n < 10) begin @(negedge clk); #1; n++; end
    check("aw_ready", 64'(rsp.aw_ready), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      req.aw_valid = 1'b0;
      req.w_valid  = 1'b1;
      req.w.data   = exp_data[b];
      req.w.strb   = strb;
      req.w.last   = (b == int'(len));
      #1;
      check("w_ready", 64'(rsp.w_ready), 64'd1);
      check("wr_req", 64'({mem_req, mem_we}), 64'd3);
      check("wr_addr", 64'(mem_addr), 64'(word0 + 16'(b * step)));
      check("wr_be", 64'(mem_be), 64'(strb));
      check("wr_data", mem_wdata, exp_data[b]);
    end
    @(negedge clk);
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    #1;
    check("b_valid", 64'(rsp.b_valid), 64'd1);
    check("b_id", 64'(rsp.b.id), 64'(id));
    check("b_resp", 64'(rsp.b.resp), 64'(AXI_RESP_OKAY));
    @(negedge clk);
    req.b_ready = 1'b0;
    #1;
    check("b_done", 64'(rsp.b_valid), 64'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [15:0] word0, input int step,
                         input int stall);
    int n;
    int beat;
    int issued;
    bit seen;
    @(negedge clk);
    req.ar = '{id: id, addr: addr, len: len, size: 3'd3, burst: burst};
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b0;
    #1;
    n = 0;
    while (!rsp.ar_ready && n < 10) begin @(negedge clk); #1; n++; end
    check("ar_ready", 64'(rsp.ar_ready), 64'd1);
    beat = 0;
    issued = 0;
    seen = 1'b0;
    for (int idx = 0; idx < 64 && beat <= int'(len); idx++) begin
      @(negedge clk);
      req.ar_valid = 1'b0;
      req.r_ready  = (idx >= stall);
      #1;
      if (mem_req && !mem_we) begin
        check("rd_addr", 64'(mem_addr), 64'(word0 + 16'(issued * step)));
        check("rd_be", 64'(mem_be), 64'hFF);
        issued++;
      end
      if (stall > 0 && idx == stall - 1) check("stall_issued", 64'(issued), 64'd2);
      if (rsp.r_valid && !seen) begin
        seen = 1'b1;
        check("r_latency", 64'(idx), 64'd2);
      end
      if (rsp.r_valid && req.r_ready) begin
        check("r_data", rsp.r.data, exp_data[beat]);
        check("r_id", 64'(rsp.r.id), 64'(id));
        check("r_last", 64'(rsp.r.last), 64'(beat == int'(len)));
        check("r_resp", 64'(rsp.r.resp), 64'(AXI_RESP_OKAY));
        beat++;
      end
    end
    check("r_beats", 64'(beat), 64'(int'(len) + 1));
    check("rd_issued", 64'(issued), 64'(int'(len) + 1));
    @(negedge clk);
    req.r_ready = 1'b0;
    #1;
    check("r_drained", 64'(rsp.r_valid), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_aw_ready"}, 64'(rsp.aw_ready), 64'd0);
    check({tag, "_ar_ready"}, 64'(rsp.ar_ready), 64'd0);
    check({tag, "_w_ready"}, 64'(rsp.w_ready), 64'd0);
    check({tag, "_b_valid"}, 64'(rsp.b_valid), 64'd0);
    check({tag, "_r_valid"}, 64'(rsp.r_valid), 64'd0);
    check({tag, "_mem"}, {mem_req, mem_we, mem_be, mem_addr}, 64'd0);
    check({tag, "_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    req = '0;
    rst_n = 1'b0;
    sram_init = 1'b1;

    // Reset with both address channels requesting: everything stays quiet.
    @(negedge clk);
    sram_init = 1'b0;
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    check_quiet("reset");
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.ar_valid = 1'b0;
    rst_n = 1'b1;

    // Single write then read back at word 8.
    exp_data[0] = 64'hDEAD_BEEF_0123_4567;
    do_write(4'd3, 64'h40, 8'd0, 2'b01, 16'h0008, 1, 8'hFF);
    do_read(4'd5, 64'h40, 8'd0, 2'b01, 16'h0008, 1, 0);

    // INCR burst of 4, read back with r_ready low for 5 cycles.
    exp_data[0] = 64'h1000_0000_0000_0008;
    exp_data[1] = 64'h1000_0000_0000_0009;
    exp_data[2] = 64'h1000_0000_0000_000A;
    exp_data[3] = 64'h1000_0000_0000_000B;
    do_write(4'd1, 64'h40, 8'd3, 2'b01, 16'h0008, 1, 8'hFF);
    do_read(4'd7, 64'h40, 8'd3, 2'b01, 16'h0008, 1, 5);

    // FIXED burst of 3 to 0x100: all at word 0x20, last beat wins.
    exp_data[0] = 64'hF0F0_0000_0000_0000;
    exp_data[1] = 64'hF1F1_0000_0000_0001;
    exp_data[2] = 64'hF2F2_0000_0000_0002;
    do_write(4'd2, 64'h100, 8'd2, AXI_BURST_FIXED, 16'h0020, 0, 8'hFF);
    exp_data[0] = 64'hF2F2_0000_0000_0002;
    do_read(4'd2, 64'h100, 8'd0, AXI_BURST_FIXED, 16'h0020, 0, 0);

    // AW/AR tie twice: write wins first, read wins second.
    @(negedge clk);
    req.aw = '{id: 4'd2, addr: 64'h200, len: 8'd0, size: 3'd3, burst: 2'b01};
    req.ar = '{id: 4'd6, addr: 64'h40, len: 8'd0, size: 3'd3, burst: 2'b01};
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    #1;
    check("tie1_aw", 64'(rsp.aw_ready), 64'd1);
    check("tie1_ar", 64'(rsp.ar_ready), 64'd0);
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1;
    req.w.data = 64'hC0C0_C0C0_0000_0000;
    req.w.strb = 8'hFF;
    req.w.last = 1'b1;
    #1;
    check("tie1_ar_held", 64'(rsp.ar_ready), 64'd0);
    check("tie1_wr", {mem_req, mem_we, mem_addr}, 64'h3_0040);
    @(negedge clk);
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    #1;
    check("tie1_b", 64'(rsp.b_valid), 64'd1);
    @(negedge clk);
    req.b_ready = 1'b0;
    req.aw = '{id: 4'd2, addr: 64'h208, len: 8'd0, size: 3'd3, burst: 2'b01};
    req.aw_valid = 1'b1;
    #1;
    check("tie2_ar", 64'(rsp.ar_ready), 64'd1);
    check("tie2_aw", 64'(rsp.aw_ready), 64'd0);
    @(negedge clk);
    req.ar_valid = 1'b0;
    req.r_ready = 1'b1;
    #1;
    check("tie2_aw_held", 64'(rsp.aw_ready), 64'd0);
    check("tie2_rd", {mem_req, mem_we, mem_addr}, 64'h2_0008);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("tie2_r_valid", 64'(rsp.r_valid), 64'd1);
    check("tie2_r_data", rsp.r.data, 64'h1000_0000_0000_0008);
    check("tie2_r_id", 64'(rsp.r.id), 64'd6);
    @(negedge clk);
    #1;
    check("tie2_aw_after", 64'(rsp.aw_ready), 64'd1);
    @(negedge clk);
    req.aw_valid = 1'b0;
    req.r_ready = 1'b0;
    req.w_valid = 1'b1;
    req.w.data = 64'hC1C1_C1C1_0000_0001;
    #1;
    check("tie2_wr", {mem_req, mem_we, mem_addr}, 64'h3_0041);
    @(negedge clk);
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    #1;
    check("tie2_b", 64'(rsp.b_valid), 64'd1);
    @(negedge clk);
    req.b_ready = 1'b0;

    // Out-of-range address wraps to word 0; partial strobe keeps low lanes.
    exp_data[0] = 64'h1111_2222_3333_4444;
    do_write(4'd1, 64'h8_0000, 8'd0, 2'b01, 16'h0000, 1, 8'hF0);
    exp_data[0] = 64'h1111_2222_5A5A_FFFF;
    do_read(4'd1, 64'h8_0000, 8'd0, 2'b01, 16'h0000, 1, 0);

    // Reset while beat 2 of an 8-beat read is on the R channel.
    @(negedge clk);
    req.ar = '{id: 4'd9, addr: 64'h400, len: 8'd7, size: 3'd3, burst: 2'b01};
    req.ar_valid = 1'b1;
    req.r_ready = 1'b1;
    #1;
    check("rst_ar_ready", 64'(rsp.ar_ready), 64'd1);
    for (int idx = 0; idx < 4; idx++) begin
      @(negedge clk);
      req.ar_valid = 1'b0;
      #1;
      if (idx >= 2) check("rst_beat", rsp.r.data, pattern(16'(16'h0080 + idx - 2)));
    end
    @(negedge clk);
    #1;
    check("rst_beat2_valid", 64'(rsp.r_valid), 64'd1);
    check("rst_beat2_data", rsp.r.data, pattern(16'h0082));
    rst_n = 1'b0;
    req.ar = '{id: 4'd4, addr: 64'h40, len: 8'd1, size: 3'd3, burst: 2'b01};
    req.ar_valid = 1'b1;
    #1;
    check_quiet("midrst");
    @(negedge clk);
    #1;
    check_quiet("midrst_hold");
    req.ar_valid = 1'b0;
    req.r_ready = 1'b0;
    rst_n = 1'b1;
    exp_data[0] = 64'h1000_0000_0000_0008;
    exp_data[1] = 64'h1000_0000_0000_0009;
    do_read(4'd4, 64'h40, 8'd1, 2'b01, 16'h0008, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
